// File: rtl/uart_tx_param_if.sv
// Handshake and status bundle between a word producer and the buffered UART transmitter.
interface uart_tx_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          send;
    logic [DATA_BITS-1:0]          data;
    logic                          txd;
    logic                          rdy;
    logic                          busy;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          overflow;

    modport master (output send, data, input txd, rdy, busy, count, overflow);
    modport slave  (input send, data, output txd, rdy, busy, count, overflow);
endinterface

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: edge-triggered push into a small FIFO, frames sent back to back
// with configurable data width, parity and stop bits.
module uart_tx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk_100mhz,
    input  logic           reset,
    uart_tx_param_if.slave bus
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nxt;
    logic [BW-1:0]        baud_cnt, baud_nxt;
    logic [3:0]           bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, sh_nxt;
    logic                 par_bit, par_nxt;
    logic                 txd_q, txd_nxt;
    logic                 ovf_q;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 send_d, push, push_ok, pop, rdy, baud_end, fifo_empty;

    assign push       = bus.send & ~send_d;
    assign rdy        = (count != CW'(FIFO_DEPTH));
    assign push_ok    = push & rdy;
    assign fifo_empty = (count == '0);
    assign baud_end   = (baud_cnt == BW'(DIV - 1));

    assign bus.txd      = txd_q;
    assign bus.rdy      = rdy;
    assign bus.busy     = (state != IDLE);
    assign bus.count    = count;
    assign bus.overflow = ovf_q;

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        par_nxt   = par_bit;
        pop       = 1'b0;
        txd_nxt   = 1'b1;
        unique case (state)
            IDLE: begin
                baud_nxt = '0;
                bit_nxt  = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: if (baud_end) begin
                baud_nxt  = '0;
                state_nxt = DATA;
            end
            DATA: if (baud_end) begin
                baud_nxt = '0;
                if (bit_cnt == 4'(DATA_BITS - 1)) begin
                    bit_nxt   = '0;
                    state_nxt = (PARITY != 0) ? PAR : STOP;
                end else begin
                    bit_nxt = bit_cnt + 4'd1;
                    sh_nxt  = shreg >> 1;
                end
            end
            PAR: if (baud_end) begin
                baud_nxt  = '0;
                state_nxt = STOP;
            end
            STOP: if (baud_end) begin
                baud_nxt = '0;
                if (bit_cnt == 4'(STOP_BITS - 1)) begin
                    bit_nxt = '0;
                    // Chain straight into the next start bit so queued words leave no idle gap.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    bit_nxt = bit_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (pop) begin
            sh_nxt  = mem[rd_ptr];
            par_nxt = (^mem[rd_ptr]) ^ (PARITY == 2);
        end
        // The line level is chosen from the state being entered so txd comes straight off a flop.
        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = sh_nxt[0];
            PAR:     txd_nxt = par_bit;
            default: txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            // Track the level during reset so a send held across reset is not seen as a new edge.
            send_d   <= bus.send;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= sh_nxt;
            par_bit  <= par_nxt;
            txd_q    <= txd_nxt;
            ovf_q    <= push & ~rdy;
            send_d   <= bus.send;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CW'(push_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!reset && push_ok) mem[wr_ptr] <= bus.data;
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Randomised and directed bench for uart_tx_param against a frame-position reference model.
module tb_uart_tx_param;
    localparam int DIV = 10;
    localparam int FRA = (1 + 8 + 0 + 1) * DIV;
    localparam int FRB = (1 + 7 + 1 + 2) * DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
    uart_tx_param_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) ifb ();
    uart_tx_param_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) ifc ();

    uart_tx_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut_a (.clk_100mhz(clk), .reset(reset), .bus(ifa.slave));
    uart_tx_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
        dut_b (.clk_100mhz(clk), .reset(reset), .bus(ifb.slave));
    uart_tx_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
        dut_c (.clk_100mhz(clk), .reset(reset), .bus(ifc.slave));

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Line level of slot idx of a frame: start, data LSB first, optional parity, then stop/idle.
    function automatic logic frame_bit(input logic [8:0] w, input int nb, input int par, input int idx);
        logic p;
        p = (par == 2);
        for (int i = 0; i < nb; i++) p = p ^ w[i];
        if (idx == 0) return 1'b0;
        if (idx <= nb) return w[idx-1];
        if (par != 0 && idx == nb + 1) return p;
        return 1'b1;
    endfunction

    // Reference model: a word queue plus cycles remaining in the frame on the wire.
    logic [7:0] q[$];
    logic [7:0] cur = '0;
    int   remain = 0;
    logic m_sd = 1'b0;
    logic m_ovf = 1'b0;
    logic m_push;
    int   pre;
    bit   chk_en = 1'b0;
    int   peak = 0;
    int   novf = 0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            remain = 0;
            m_sd   = ifa.send;
            m_ovf  = 1'b0;
        end else begin
            m_push = ifa.send & ~m_sd;
            m_sd   = ifa.send;
            pre    = q.size();
            m_ovf  = m_push && (pre == 4);
            if (remain > 0) remain--;
            if (remain == 0 && pre > 0) begin
                cur    = q.pop_front();
                remain = FRA;
            end
            if (m_push && pre != 4) q.push_back(ifa.data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("txd",   ifa.txd, (remain == 0) ? 1'b1 : frame_bit({1'b0, cur}, 8, 0, (FRA - remain) / DIV));
            chk("busy",  ifa.busy, remain != 0);
            chk("count", ifa.count, q.size());
            chk("rdy",   ifa.rdy, q.size() != 4);
            chk("ovf",   ifa.overflow, m_ovf);
            if (int'(ifa.count) > peak) peak = int'(ifa.count);
            novf += int'(ifa.overflow);
        end
    end

    task automatic push_a(input logic [7:0] d);
        @(negedge clk);
        ifa.send = 1'b1;
        ifa.data = d;
        @(negedge clk);
        ifa.send = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((remain != 0 || q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (remain != 0 || q.size() != 0) chk("idle_tmo", 0, 1);
    endtask

    task automatic wait_remain(input int r);
        int n = 0;
        while (remain != r && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (remain != r) chk("remain_tmo", 0, 1);
    endtask

    initial begin
        ifa.send = 1'b0; ifa.data = '0;
        ifb.send = 1'b0; ifb.data = '0;
        ifc.send = 1'b0; ifc.data = '0;
        repeat (3) @(negedge clk);
        chk("rst_txd",   ifa.txd, 1);
        chk("rst_rdy",   ifa.rdy, 1);
        chk("rst_busy",  ifa.busy, 0);
        chk("rst_count", ifa.count, 0);
        chk("rst_ovf",   ifa.overflow, 0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Single 8N1 frame on A; 7-bit odd/even parity, two stop bits on B and C.
        @(negedge clk);
        ifa.send = 1'b1; ifa.data = 8'hA5;
        ifb.send = 1'b1; ifb.data = 7'h55;
        ifc.send = 1'b1; ifc.data = 7'h55;
        @(negedge clk);
        ifa.send = 1'b0; ifb.send = 1'b0; ifc.send = 1'b0;
        @(negedge clk);
        for (int k = 0; k < FRB + 4; k++) begin
            chk("b_txd",  ifb.txd, (k < FRB) ? frame_bit(9'h55, 7, 2, k / DIV) : 1'b1);
            chk("c_txd",  ifc.txd, (k < FRB) ? frame_bit(9'h55, 7, 1, k / DIV) : 1'b1);
            chk("b_busy", ifb.busy, k < FRB);
            if (k == FRA - 1 || k == FRA) chk("a_len", ifa.busy, k < FRA);
            @(negedge clk);
        end
        wait_idle(400);

        // Six pushes two cycles apart starting from idle: first pops, next four fill, sixth drops.
        peak = 0; novf = 0;
        repeat (6) push_a(8'($urandom));
        wait_idle(6 * FRA + 100);
        chk("fill_peak", peak, 4);
        chk("fill_ovf",  novf, 1);

        // Held send gives exactly one push.
        peak = 0;
        @(negedge clk);
        ifa.send = 1'b1; ifa.data = 8'($urandom);
        repeat (500) @(negedge clk);
        ifa.send = 1'b0;
        wait_idle(400);
        chk("held_peak", peak, 1);

        // Push coinciding with the pop at the last stop cycle, one word queued.
        push_a(8'h3C);
        push_a(8'hC3);
        wait_remain(1);
        ifa.send = 1'b1; ifa.data = 8'h81;
        @(negedge clk);
        ifa.send = 1'b0;
        chk("sim_cnt",  ifa.count, 1);
        chk("sim_txd",  ifa.txd, 0);
        chk("sim_busy", ifa.busy, 1);
        // Same again while full: the push must be dropped.
        repeat (3) push_a(8'($urandom));
        wait_remain(1);
        ifa.send = 1'b1; ifa.data = 8'h7E;
        @(negedge clk);
        ifa.send = 1'b0;
        chk("full_ovf", ifa.overflow, 1);
        chk("full_cnt", ifa.count, 3);
        wait_idle(6 * FRA);

        // Reset 35 cycles into a frame with two words queued.
        repeat (3) push_a(8'($urandom));
        wait_remain(FRA - 35);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_txd",   ifa.txd, 1);
        chk("mr_count", ifa.count, 0);
        chk("mr_busy",  ifa.busy, 0);
        chk("mr_rdy",   ifa.rdy, 1);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        chk("mr_quiet", ifa.busy, 0);

        // Random pushes, data and occasional resets.
        repeat (4000) begin
            @(negedge clk);
            ifa.send = ($urandom_range(0, 15) == 0);
            ifa.data = 8'($urandom);
            reset    = ($urandom_range(0, 699) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        ifa.send = 1'b0;
        wait_idle(6 * FRA);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
